multi_cycle_controller: RTL and testbench
=========================================

Name: multi_cycle_controller

Overview:
- FSM that sequences the shared multi-cycle RISC-V datapath: one ALU, one unified instruction/data memory, IR, MDR, ALUOut and PC registers.
- Decodes the opcode held in the IR and drives per-state datapath enables and mux selects.
- Waits on a memory ready handshake.
- Replaces combinational per-opcode decode in the multi-cycle CPU top level.

Parameters:
- RESET_STATE, 3'd0, state entered on reset (S_IF). Other values unsupported.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- opcode  input  7  IR[6:0].
- alu_bcond  input  1  ALU branch-compare result, valid in S_EX for BRANCH.
- mem_ready  input  1  memory completes the current access this cycle.
- halt_cond  input  1  x17==10 from register file (used only with feature).
- mem_read  output  1  memory read request, held until mem_ready.
- mem_write  output  1  memory write request, held until mem_ready.
- i_or_d  output  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  output  1  load IR from memory data.
- mdr_write  output  1  load MDR from memory data.
- aluout_write  output  1  load ALUOut from ALU result.
- alu_src_a  output  1  0 = PC, 1 = rs1 (A).
- alu_src_b  output  2  00 = rs2 (B), 01 = constant 4, 10 = immediate.
- alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- reg_write  output  1  register file write enable.
- wb_sel  output  2  00 = ALUOut, 01 = MDR, 10 = live ALU result (PC+4).
- pc_write  output  1  PC update enable.
- pc_source  output  1  0 = live ALU result, 1 = ALUOut.
- is_halted  output  1  processor halted (feature only; else tied 0).

Behaviour:
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- States (3-bit): S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_HALT=5.
- Reset: state <= S_IF, internal branch_taken <= 0, is_halted <= 0.
- Reset is synchronous and overrides any state, including mid-memory-access. Requests drop the cycle after reset is sampled.
- Outputs are Moore-style from state and opcode. All outputs default to 0 unless listed below; mem_ready gates only ir_write/mdr_write and transitions.
- S_IF: mem_read=1, i_or_d=0. When mem_ready: ir_write=1, go to S_ID. Otherwise stay in S_IF.
- S_ID: alu_src_a=0, alu_src_b=10, alu_op=00, aluout_write=1 (ALUOut=PC+imm).
  - JAL or ECALL -> S_WB.
  - All other opcodes -> S_EX.
- S_EX, R: alu_src_a=1, b=00, op=10, aluout_write=1 -> S_WB.
- S_EX, I-ALU: alu_src_a=1, b=10, op=10, aluout_write=1 -> S_WB.
- S_EX, LOAD/STORE: alu_src_a=1, b=10, op=00, aluout_write=1 -> S_MEM.
- S_EX, JALR: alu_src_a=1, b=10, op=00, aluout_write=1 -> S_WB.
- S_EX, BRANCH: alu_src_a=1, b=00, op=01, aluout_write=0 (target preserved). Registers branch_taken<=alu_bcond, then -> S_WB.
- S_EX, unknown opcode: no enables -> S_WB.
- S_MEM: i_or_d=1 and mem_read=1 (LOAD) or mem_write=1 (STORE), held until mem_ready.
  - LOAD: mdr_write=1 on the mem_ready cycle.
  - Then -> S_WB. No timeout.
- S_WB: alu_src_a=0, alu_src_b=01, op=00 (ALU=PC+4), pc_write=1 -> S_IF.
  - pc_source=1 for JAL, JALR, and BRANCH with branch_taken=1. Otherwise 0.
  - reg_write=1 for R, I-ALU, LOAD, JAL, JALR.
  - wb_sel=00 for R/I-ALU, 01 for LOAD, 10 for JAL/JALR.
  - STORE, BRANCH, ECALL and unknown opcodes: reg_write=0.
  - branch_taken is cleared in S_WB.
- Latency with zero-wait memory (mem_ready tied 1):
  - JAL/ECALL 3 cycles; R/I/JALR/BRANCH 4; LOAD/STORE 5.
  - Each memory wait cycle adds 1.
- S_HALT is unreachable without the feature. An illegal state encoding -> S_IF next cycle.

Optional Feature:
- Macro ECALL_HALT_EN.
- Defined: in S_ID with ECALL and halt_cond=1, next state is S_HALT instead of S_WB.
  - S_HALT: all enables 0 and is_halted=1, held until reset.
  - ECALL with halt_cond=0 behaves as a NOP.
- Undefined: ECALL is always a NOP (PC+4), halt_cond is ignored, is_halted is constant 0.

Test Plan:
- reset=1 for 2 cycles, then R-type (0110011), mem_ready=1 -> states IF,ID,EX,WB. reg_write=1 and wb_sel=00 only in WB; pc_write=1 only in WB, with pc_source=0.
- LOAD with mem_ready low 3 cycles in S_MEM -> mem_read=1 and i_or_d=1 held 4 cycles; mdr_write pulses once; WB with wb_sel=01; total 8 cycles.
- BRANCH: alu_bcond=1 -> WB with pc_source=1, reg_write=0. Repeat with alu_bcond=0 -> pc_source=0.
- JAL -> IF,ID,WB (3 cycles); WB with reg_write=1, wb_sel=10, pc_source=1, no S_EX visit.
- ECALL, halt_cond=1: with ECALL_HALT_EN -> S_HALT, is_halted=1 stays for 10+ cycles, all enables 0. Without the macro -> WB with pc_source=0, is_halted=0.
- reset asserted during S_MEM store wait -> next cycle state=S_IF, mem_write=0, mem_read=1 (fetch restarts).

Source files
------------

// File: rtl/multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller
//
// Main control FSM for the shared multi-cycle RISC-V datapath (one ALU, one
// unified instruction/data memory, IR, MDR, ALUOut and PC registers).
//
// The FSM walks IF -> ID -> [EX] -> [MEM] -> WB for every instruction. It
// decodes the opcode held in the IR and produces the datapath enables and mux
// selects for each step.
//
// Control outputs are registered. They are computed from the state being
// entered, so the values seen in a cycle are a pure function of the current
// state and opcode. The opcode comes from the IR, and the IR is stable from
// ID onward.
//
// ir_write and mdr_write are the exception. They must land on the exact cycle
// memory completes, so the registered enable is ANDed with the live mem_ready.
//
// Optional feature, enabled by defining ECALL_HALT_EN:
//   When halt_cond is high, an ECALL seen in ID parks the FSM in S_HALT with
//   is_halted=1 until reset. Without the macro, every ECALL is a plain NOP
//   (PC+4), halt_cond is ignored, and is_halted is tied to 0.
// -----------------------------------------------------------------------------
module multi_cycle_controller #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    input  logic       halt_cond,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       aluout_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic       pc_source,
    output logic       is_halted
);

    // RV32 base opcodes handled by this controller
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    // ALU operand / operation / write-back select encodings
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } stateT;

    // One bundle holding every registered control output. irWriteEn and
    // mdrWriteEn are qualified by mem_ready before they leave the block.
    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       iOrD;
        logic       irWriteEn;
        logic       mdrWriteEn;
        logic       aluoutWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       regWrite;
        logic [1:0] wbSel;
        logic       pcWrite;
        logic       pcSource;
    } ctrlT;

    stateT r_state;
    logic  r_branchTaken;
    ctrlT  r_ctrl;

    stateT w_nextState;
    logic  w_nextTaken;
    ctrlT  w_nextCtrl;

    // Control word for a given state. In WB, 'taken' is the branch_taken
    // value that will be held while that state is active.
    function automatic ctrlT decodeCtrl(input stateT st,
                                        input logic [6:0] op,
                                        input logic taken);
        ctrlT c;
        c = '0;
        case (st)
            S_IF: begin
                c.memRead   = 1'b1;
                c.iOrD      = 1'b0;
                c.irWriteEn = 1'b1;
            end
            S_ID: begin
                // Speculatively form the branch/JAL target PC+imm in ALUOut
                c.aluSrcA     = 1'b0;
                c.aluSrcB     = SRCB_IMM;
                c.aluOp       = ALU_ADD;
                c.aluoutWrite = 1'b1;
            end
            S_EX: begin
                case (op)
                    OP_R: begin
                        c.aluSrcA     = 1'b1;
                        c.aluSrcB     = SRCB_RS2;
                        c.aluOp       = ALU_FUNCT;
                        c.aluoutWrite = 1'b1;
                    end
                    OP_I: begin
                        c.aluSrcA     = 1'b1;
                        c.aluSrcB     = SRCB_IMM;
                        c.aluOp       = ALU_FUNCT;
                        c.aluoutWrite = 1'b1;
                    end
                    OP_LOAD, OP_STORE, OP_JALR: begin
                        c.aluSrcA     = 1'b1;
                        c.aluSrcB     = SRCB_IMM;
                        c.aluOp       = ALU_ADD;
                        c.aluoutWrite = 1'b1;
                    end
                    OP_BRANCH: begin
                        // ALUOut keeps the target computed in ID
                        c.aluSrcA = 1'b1;
                        c.aluSrcB = SRCB_RS2;
                        c.aluOp   = ALU_CMP;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                c.iOrD = 1'b1;
                if (op == OP_LOAD) begin
                    c.memRead    = 1'b1;
                    c.mdrWriteEn = 1'b1;
                end else if (op == OP_STORE) begin
                    c.memWrite = 1'b1;
                end
            end
            S_WB: begin
                // The ALU forms PC+4 live; it is used as the next PC or as the link value
                c.aluSrcA = 1'b0;
                c.aluSrcB = SRCB_FOUR;
                c.aluOp   = ALU_ADD;
                c.pcWrite = 1'b1;
                case (op)
                    OP_R, OP_I: begin
                        c.regWrite = 1'b1;
                        c.wbSel    = WB_ALUOUT;
                    end
                    OP_LOAD: begin
                        c.regWrite = 1'b1;
                        c.wbSel    = WB_MDR;
                    end
                    OP_JAL, OP_JALR: begin
                        c.regWrite = 1'b1;
                        c.wbSel    = WB_PC4;
                        c.pcSource = 1'b1;
                    end
                    OP_BRANCH: begin
                        c.pcSource = taken;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state and branch_taken update rules
    always_comb begin
        w_nextState = S_IF;
        w_nextTaken = r_branchTaken;
        case (r_state)
            S_IF: begin
                w_nextState = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                if (opcode == OP_JAL) begin
                    w_nextState = S_WB;
                end else if (opcode == OP_ECALL) begin
`ifdef ECALL_HALT_EN
                    w_nextState = halt_cond ? S_HALT : S_WB;
`else
                    w_nextState = S_WB;
`endif
                end else begin
                    w_nextState = S_EX;
                end
            end
            S_EX: begin
                if (opcode == OP_BRANCH) begin
                    w_nextTaken = alu_bcond;
                end
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    w_nextState = S_MEM;
                end else begin
                    w_nextState = S_WB;
                end
            end
            S_MEM: begin
                w_nextState = mem_ready ? S_WB : S_MEM;
            end
            S_WB: begin
                w_nextState = S_IF;
                w_nextTaken = 1'b0;
            end
            S_HALT: begin
`ifdef ECALL_HALT_EN
                w_nextState = S_HALT;
`else
                w_nextState = S_IF;
`endif
            end
            default: begin
                w_nextState = S_IF;
            end
        endcase
    end

    assign w_nextCtrl = decodeCtrl(w_nextState, opcode, w_nextTaken);

    // State, branch flag and registered control word; reset wins over any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= stateT'(RESET_STATE);
            r_branchTaken <= 1'b0;
            r_ctrl        <= decodeCtrl(stateT'(RESET_STATE), opcode, 1'b0);
        end else begin
            r_state       <= w_nextState;
            r_branchTaken <= w_nextTaken;
            r_ctrl        <= w_nextCtrl;
        end
    end

`ifdef ECALL_HALT_EN
    logic r_isHalted;

    // Halt flag tracks entry into S_HALT and is only cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_isHalted <= 1'b0;
        end else begin
            r_isHalted <= (w_nextState == S_HALT);
        end
    end

    assign is_halted = r_isHalted;
`else
    logic w_unusedHaltCond;
    assign w_unusedHaltCond = halt_cond;
    assign is_halted        = 1'b0;
`endif

    assign mem_read     = r_ctrl.memRead;
    assign mem_write    = r_ctrl.memWrite;
    assign i_or_d       = r_ctrl.iOrD;
    assign ir_write     = r_ctrl.irWriteEn & mem_ready;
    assign mdr_write    = r_ctrl.mdrWriteEn & mem_ready;
    assign aluout_write = r_ctrl.aluoutWrite;
    assign alu_src_a    = r_ctrl.aluSrcA;
    assign alu_src_b    = r_ctrl.aluSrcB;
    assign alu_op       = r_ctrl.aluOp;
    assign reg_write    = r_ctrl.regWrite;
    assign wb_sel       = r_ctrl.wbSel;
    assign pc_write     = r_ctrl.pcWrite;
    assign pc_source    = r_ctrl.pcSource;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_controller
//
// Instruction-level reference model and scoreboard for multi_cycle_controller.
//
// For each instruction, the driver works out the cycle-by-cycle phase list
// from the instruction-class rules: fetch waits, ID, optional EX, MEM with
// waits, and WB. For every cycle it drives, it pushes the control word it
// expects into a queue. A separate monitor pops one entry on every falling
// edge and compares it against the DUT outputs.
//
// Define ECALL_HALT_EN here as well as in the RTL to check the halt path.
// -----------------------------------------------------------------------------
module tb_multi_cycle_controller;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

`ifdef ECALL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       alu_bcond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       halt_cond = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, mdr_write, aluout_write;
    logic       alu_src_a, reg_write, pc_write, pc_source, is_halted;
    logic [1:0] alu_src_b, alu_op, wb_sel;

    typedef struct {
        logic [16:0] v;
        string       tag;
    } expT;

    expT expQ[$];
    int  testCount = 0;
    int  failCount = 0;
    bit  monActive = 1'b0;

    multi_cycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .alu_bcond   (alu_bcond),
        .mem_ready   (mem_ready),
        .halt_cond   (halt_cond),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .mdr_write   (mdr_write),
        .aluout_write(aluout_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .pc_write    (pc_write),
        .pc_source   (pc_source),
        .is_halted   (is_halted)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Pack the expected outputs in port order
    function automatic logic [16:0] mk(input logic mr, input logic mw, input logic iod,
                                       input logic irw, input logic mdrw, input logic aow,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic rw,
                                       input logic [1:0] wb, input logic pw,
                                       input logic ps, input logic h);
        return {mr, mw, iod, irw, mdrw, aow, sa, sb, aop, rw, wb, pw, ps, h};
    endfunction

    function automatic logic [16:0] expIF(input logic rdy);
        return mk(1, 0, 0, rdy, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
    endfunction

    function automatic logic [16:0] expID();
        return mk(0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0);
    endfunction

    function automatic logic [16:0] expEX(input logic [6:0] op);
        if (op == OP_R)
            return mk(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b10, 0, 2'b00, 0, 0, 0);
        if (op == OP_I)
            return mk(0, 0, 0, 0, 0, 1, 1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0);
        if (op == OP_LOAD || op == OP_STORE || op == OP_JALR)
            return mk(0, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0);
        if (op == OP_BRANCH)
            return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0);
        return '0;
    endfunction

    function automatic logic [16:0] expMEM(input logic [6:0] op, input logic rdy);
        logic isLoad;
        isLoad = (op == OP_LOAD);
        return mk(isLoad, !isLoad, 1, 0, isLoad & rdy, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
    endfunction

    function automatic logic [16:0] expWB(input logic [6:0] op, input logic taken);
        logic       rw, ps;
        logic [1:0] wb;
        rw = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_JAL) || (op == OP_JALR);
        wb = (op == OP_LOAD) ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00);
        ps = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH && taken);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, rw, wb, 1, ps, 0);
    endfunction

    function automatic logic [16:0] expHALT();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1);
    endfunction

    function automatic logic isKnown(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE ||
               op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_ECALL;
    endfunction

    function automatic logic [6:0] pickOp();
        logic [6:0] op;
        case ($urandom_range(8, 0))
            0: op = OP_R;
            1: op = OP_I;
            2: op = OP_LOAD;
            3: op = OP_STORE;
            4: op = OP_BRANCH;
            5: op = OP_JAL;
            6: op = OP_JALR;
            7: op = OP_ECALL;
            default: begin
                op = 7'($urandom);
                while (isKnown(op)) op = 7'($urandom);
            end
        endcase
        return op;
    endfunction

    // Drive one cycle of inputs and record what the DUT must show during it
    task automatic driveCycle(input logic rdy, input logic [6:0] op, input logic bc,
                              input logic hc, input logic rst,
                              input logic [16:0] exp, input string tag);
        expT e;
        mem_ready = rdy;
        opcode    = op;
        alu_bcond = bc;
        halt_cond = hc;
        reset     = rst;
        e.v   = exp;
        e.tag = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One complete instruction; rstInMem >= 0 asserts reset on that MEM wait cycle
    task automatic applyStimulus(input logic [6:0] op, input logic bc, input int fw,
                                 input int mw, input logic hc, input int rstInMem);
        logic memOp;
        memOp = (op == OP_LOAD) || (op == OP_STORE);
        for (int i = 0; i < fw; i++)
            driveCycle(0, 7'($urandom), rb(), rb(), 0, expIF(0), "IF.wait");
        driveCycle(1, 7'($urandom), rb(), rb(), 0, expIF(1), "IF");
        driveCycle(rb(), op, rb(), hc, 0, expID(), "ID");
        if (op == OP_ECALL && hc && HALT_EN) begin
            for (int i = 0; i < 12; i++)
                driveCycle(rb(), op, rb(), rb(), 0, expHALT(), "HALT");
            driveCycle(0, op, rb(), rb(), 1, expHALT(), "HALT.rst");
            return;
        end
        if (op != OP_JAL && op != OP_ECALL)
            driveCycle(rb(), op, bc, rb(), 0, expEX(op), "EX");
        if (memOp) begin
            for (int i = 0; i < mw; i++) begin
                if (i == rstInMem) begin
                    driveCycle(0, op, rb(), rb(), 1, expMEM(op, 0), "MEM.rst");
                    return;
                end
                driveCycle(0, op, rb(), rb(), 0, expMEM(op, 0), "MEM.wait");
            end
            driveCycle(1, op, rb(), rb(), 0, expMEM(op, 1), "MEM");
        end
        driveCycle(rb(), op, rb(), rb(), 0, expWB(op, bc), "WB");
    endtask

    // Scoreboard monitor: one expected control word per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (monActive) begin
            logic [16:0] act;
            expT         e;
            act = {mem_read, mem_write, i_or_d, ir_write, mdr_write, aluout_write,
                   alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, pc_write,
                   pc_source, is_halted};
            testCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL underflow: got %b with no expected entry", act);
            end else begin
                e = expQ.pop_front();
                if (act !== e.v) begin
                    failCount++;
                    $display("[TB] FAIL %s: got %b expected %b (op %b)", e.tag, act, e.v, opcode);
                end
            end
        end
    end

    initial begin
        int fw, mw, rstAt;
        logic [6:0] op;
        @(posedge clk);
        #1;
        monActive = 1'b1;
        driveCycle(0, 7'($urandom), 0, 0, 1, expIF(0), "RST");

        // Directed cases
        applyStimulus(OP_R,      0, 0, 0, 0, -1);
        applyStimulus(OP_LOAD,   0, 0, 3, 0, -1);
        applyStimulus(OP_BRANCH, 1, 0, 0, 0, -1);
        applyStimulus(OP_BRANCH, 0, 0, 0, 0, -1);
        applyStimulus(OP_JAL,    0, 0, 0, 0, -1);
        applyStimulus(OP_ECALL,  0, 0, 0, 1, -1);
        applyStimulus(OP_STORE,  0, 1, 3, 0, 1);
        applyStimulus(OP_JALR,   0, 2, 0, 0, -1);
        applyStimulus(OP_STORE,  0, 0, 0, 0, -1);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op    = pickOp();
            fw    = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            mw    = int'($urandom_range(3, 0));
            rstAt = ($urandom_range(9, 0) == 0) ? 0 : -1;
            applyStimulus(op, rb(), fw, mw, rb(), rstAt);
        end

        monActive = 1'b0;
        testCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d leftover entries, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
